// File: rtl/pending_encoder_16_4.sv
// Pending-event encoder: gathers up to 16 request lines into a sticky
// pending register and hands them out one index at a time over a
// valid/ack handshake. The served bit is cleared when the consumer accepts.
// HIGH_FIRST selects whether the lowest (0) or highest (1) pending index wins.
module pending_encoder_16_4 #(
    parameter bit HIGH_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] req,
    input  logic        ack,
    output logic [3:0]  o,
    output logic        valid,
    output logic [15:0] pending,
    output logic        dup
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_o;
    logic        r_valid;
    logic [15:0] r_pending;
    logic        r_dup;

    logic [15:0] w_served;
    logic [15:0] w_cap;
    logic [15:0] w_remain;
    logic [15:0] w_pending_next;
    logic        w_dup_next;
    logic        w_any;
    logic [3:0]  w_sel;

    // Priority encoder: the last matching bit visited in the scan wins,
    // so the scan direction decides which end of the vector has priority.
    function automatic logic [3:0] prio_enc(input logic [15:0] vec,
                                            input bit          high_first);
        logic [3:0] idx;
        idx = 4'd0;
        if (high_first) begin
            for (int i = 0; i < 16; i++) begin
                idx = vec[i] ? 4'(i) : idx;
            end
        end else begin
            for (int i = 15; i >= 0; i--) begin
                idx = vec[i] ? 4'(i) : idx;
            end
        end
        return idx;
    endfunction

    // Handshake mask, capture gating, and next-state of the pending set.
    always_comb begin
        w_served = 16'h0000;
        if (r_valid && ack) begin
            w_served = 16'h0001 << r_o;
        end else begin
            w_served = 16'h0000;
        end

        w_cap = 16'h0000;
        if (enable) begin
            w_cap = req;
        end else begin
            w_cap = 16'h0000;
        end

        // The just-accepted bit is masked out so it is never re-selected;
        // freshly captured bits only become selectable next cycle.
        w_remain       = r_pending & ~w_served;
        w_pending_next = w_remain | w_cap;
        w_dup_next     = |(w_cap & w_remain);
        w_any          = |w_remain;
        w_sel          = prio_enc(w_remain, HIGH_FIRST);
    end

    // Pending register, duplicate pulse, and the IDLE/PRESENT handshake FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_o       <= 4'd0;
            r_valid   <= 1'b0;
            r_pending <= 16'h0000;
            r_dup     <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            r_dup     <= w_dup_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_o     <= w_sel;
                        r_valid <= 1'b1;
                        r_state <= ST_PRESENT;
                    end else begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_PRESENT: begin
                    if (!ack) begin
                        // Hold the presented index; no preemption.
                        r_valid <= 1'b1;
                        r_state <= ST_PRESENT;
                    end else if (w_any) begin
                        r_o     <= w_sel;
                        r_valid <= 1'b1;
                        r_state <= ST_PRESENT;
                    end else begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o       = r_o;
    assign valid   = r_valid;
    assign pending = r_pending;
    assign dup     = r_dup;

endmodule

// File: doc/pending_encoder_16_4.md
Name: pending_encoder_16_4

Overview:
Inverse of the team's 4-to-16 one-hot decoder: collects up to 16 event/request lines into a sticky pending register and encodes them back into a 4-bit index, one event at a time. Each encoded index is presented with a valid/ack handshake, and the served bit is cleared on acceptance. Sits between event sources (decoded selects, interrupt-style flags) and a consumer that handles one index per transfer.

Parameters:
HIGH_FIRST, 0, priority order: 0 = lowest pending index wins, 1 = highest pending index wins.

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  1 = capture req into pending; 0 = req ignored (drain and handshake continue)
req  input  16  request lines, sampled every clock while enable=1; multi-hot allowed
ack  input  1  consumer accepts current o when valid=1 and ack=1
o  output  4  encoded index of presented request (registered)
valid  output  1  o holds a pending request (registered)
pending  output  16  current sticky pending register
dup  output  1  one-cycle pulse: a req bit arrived while already pending (event merged/lost)

Behaviour:
- Reset (reset=1 at a rising edge): pending=0, o=0, valid=0, dup=0, state=IDLE. Reset overrides all inputs, including ack and req in the same cycle.
- served[15:0] = one-hot(o) when valid&ack, else 0.
- cap[15:0] = req when enable=1, else 0.
- pending_next = (pending & ~served) | cap. Set wins over clear on the same bit.
- dup_next = |(cap & pending & ~served). A bit being served in the same cycle is re-pended without a dup.
- sel = priority-encode(pending & ~served) per HIGH_FIRST. The mask uses current-cycle values, so a just-accepted bit is never re-selected on the next transfer. Newly captured cap bits are not visible until the following cycle.
- FSM, 2 states:
  - IDLE (valid=0): if (pending & ~served) != 0, then o<=sel, valid<=1, go PRESENT. Otherwise stay, and o holds its last value.
  - PRESENT (valid=1):
    - ack=0: o and valid held stable. A newly pending higher-priority bit does NOT preempt.
    - ack=1 and (pending & ~served) != 0: o<=sel, valid stays 1. Back-to-back transfers, one per clock.
    - ack=1 and none remaining: valid<=0, go IDLE, o holds.
- Latency: req at edge N → pending[k]=1 after edge N → valid=1, o=k after edge N+1 (2 clocks from an idle block).
- Throughput: 1 index per clock with ack held high.
- ack while valid=0: ignored, clears nothing.
- enable=0: pending only decrements. An in-flight presentation completes normally.
- All 16 bits pending: drained in priority order over 16 acked cycles; o wraps nothing (pure index), and valid falls after the last ack.
- Reset mid-transfer: valid=0 and pending=0 after the edge. The interrupted index is discarded and must not reappear.
- Encoded o always satisfies pending[o]=1 whenever valid=1 (verification invariant).

Test Plan:
- Reset, then req=16'h0000 for 5 cycles -> valid=0, o=0, pending=0, dup=0 throughout.
- HIGH_FIRST=0, single-cycle req=16'h0000→16'h8421, ack=1 continuously -> pending=16'h8421 next cycle; o sequence 0,5,10,15 on consecutive cycles with valid=1; valid=0 on the following cycle; pending=0.
- HIGH_FIRST=1, req=16'h0081 pulse, ack=0 for 4 cycles, then req=16'h4000 pulse -> o stays 7 (no preempt) while ack=0. After ack: o=14, then o=0, then valid=0.
- Duplicate: req=16'h0010 two consecutive cycles, ack=0 -> dup=1 for exactly one cycle. With ack accepting o=4 in the same cycle as req[4] -> pending[4] stays 1, dup=0, and o=4 is presented again.
- enable=0 with req=16'hFFFF, pending=16'h0006, ack=1 -> o=1 then o=2, then valid=0; pending never gains bits.
- Mid-drain reset: pending=16'hF000, valid=1, o=12, reset=1 with ack=1 -> after edge, valid=0, pending=0, dup=0; no further valid until new req.
